// File: rtl/key_led_pkg.sv
// Shared mode encodings, LED pattern constants and the RUN rotation helper
// for the key/LED controller.
package key_led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALL_ON = 2'd1,
    MODE_RUN    = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [3:0] LED_ALL_ON   = 4'b1111;
  localparam logic [3:0] LED_ALL_OFF  = 4'b0000;
  localparam logic [3:0] LED_RUN_INIT = 4'b0001;

  // dir=0 walks the lit LED towards bit 3, dir=1 towards bit 0
  function automatic logic [3:0] rotate_led(input logic [3:0] pat, input logic dir);
    return dir ? {pat[0], pat[3:1]} : {pat[2:0], pat[3]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key input: 2-FF synchroniser, stability counter, debounced level and a
// one-cycle press pulse on each accepted 1->0 transition (keys are active-low).
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The new level is accepted on the DEB_CYCLES-th consecutive differing sample
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Four debounced keys drive a mode FSM (off / all-on / running light / blink).
// Optional long key0 hold forcing OFF is built when KEY_LONG_PRESS_EN is defined.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned STEP_CYCLES = 12_500_000,
  parameter int unsigned LONG_CYCLES = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [3:0]        key,
  output logic [3:0]        led,
  output logic [MODE_W-1:0] mode
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic [3:0]    key_level;
  logic [3:0]    press;
  mode_e         mode_q, mode_d;
  logic [3:0]    led_q, led_d;
  logic          dir_q, dir_d;
  logic          paused_q, paused_d;
  logic          entry_q, entry_d;
  logic [SW-1:0] step_q, step_d;
  logic          tick;
  logic          mode_evt;
  logic          long_fire;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .key_in (key[i]),
      .level  (key_level[i]),
      .press  (press[i])
    );
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_done_q, long_done_d;
  logic          unused_level;

  assign unused_level = ^key_level[3:1];

  // long_done blocks a second force-to-OFF until key0 is released
  always_comb begin
    hold_d      = hold_q;
    long_done_d = long_done_q;
    long_fire   = 1'b0;
    if (key_level[0]) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end else if (!long_done_q) begin
      if (hold_q == HOLD_LAST) begin
        long_fire   = 1'b1;
        long_done_d = 1'b1;
        hold_d      = '0;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q      <= '0;
      long_done_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{key_level, 1'(LONG_CYCLES % 2)};
  assign long_fire  = 1'b0;
`endif

  // A frozen counter may sit on STEP_LAST, so the tick is also gated by pause
  always_comb begin
    mode_evt = press[0] | press[1] | long_fire;
    tick     = (step_q == STEP_LAST) && !paused_q;

    mode_d = mode_q;
    if (press[0]) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end else if (press[1]) begin
      mode_d = mode_e'(mode_q - 2'd1);
    end
    if (long_fire) begin
      mode_d = MODE_OFF;
    end

    dir_d    = dir_q ^ press[3];
    paused_d = mode_evt ? 1'b0 : (paused_q ^ press[2]);
    entry_d  = mode_evt;

    if (mode_evt) begin
      step_d = '0;
    end else if (paused_q) begin
      step_d = step_q;
    end else if (step_q == STEP_LAST) begin
      step_d = '0;
    end else begin
      step_d = step_q + SW'(1);
    end

    // LED pattern trails the mode register by one cycle; entry_q marks a fresh mode
    led_d = led_q;
    case (mode_q)
      MODE_OFF:    led_d = LED_ALL_OFF;
      MODE_ALL_ON: led_d = LED_ALL_ON;
      MODE_RUN: begin
        if (entry_q) begin
          led_d = LED_RUN_INIT;
        end else if (tick) begin
          led_d = rotate_led(led_q, dir_q);
        end
      end
      MODE_BLINK: begin
        if (entry_q) begin
          led_d = LED_ALL_ON;
        end else if (tick) begin
          led_d = ~led_q;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q   <= MODE_OFF;
      led_q    <= LED_ALL_OFF;
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
      entry_q  <= 1'b0;
      step_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      entry_q  <= entry_d;
      step_q   <= step_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Self-checking bench for key_led_ctrl: directed mode/LED timing steps followed by
// randomized key presses against a behavioural model of modes, pause and direction.
module tb_key_led_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 8;
  localparam int LONG = 32;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [3:0] key       = 4'hF;
  logic [3:0] led;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  int m_mode   = 0;
  bit m_dir    = 1'b0;
  bit m_paused = 1'b0;

  key_led_ctrl #(
    .DEB_CYCLES  (DEB),
    .STEP_CYCLES (STEP),
    .LONG_CYCLES (LONG)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .led       (led),
    .mode      (mode)
  );

  always #5 sys_clk = ~sys_clk;

  // RUN pattern as a lit position moving ticks places from the start position
  function automatic logic [3:0] run_pattern(input logic [3:0] start, input bit dir, input int ticks);
    int pos0 = 0;
    int pos;
    for (int b = 0; b < 4; b++) if (start[b]) pos0 = b;
    pos = dir ? (pos0 + 4 - (ticks % 4)) % 4 : (pos0 + ticks) % 4;
    return 4'(1 << pos);
  endfunction

  function automatic logic [3:0] blink_pattern(input int ticks);
    return (ticks % 2 == 0) ? 4'hF : 4'h0;
  endfunction

  function automatic void applyModel(input logic [3:0] mask);
    if (mask[0]) m_mode = (m_mode + 1) % 4;
    else if (mask[1]) m_mode = (m_mode + 3) % 4;
    if (mask[2]) m_paused = !m_paused;
    if (mask[3]) m_dir = !m_dir;
    if (mask[1:0] != 2'b00) m_paused = 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkMode(input string tag);
    checkOutput(tag, {2'b00, mode}, 4'(m_mode));
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int low_cycles);
    @(negedge sys_clk);
    key = key & ~mask;
    repeat (low_cycles) @(negedge sys_clk);
    key = key | mask;
  endtask

  task automatic bouncePrefix(input logic [3:0] mask);
    @(negedge sys_clk);
    key = key & ~mask;
    repeat (DEB - 1) @(negedge sys_clk);
    key = key | mask;
  endtask

  task automatic pressKey(input logic [3:0] mask, input bit bounce);
    repeat (8) @(negedge sys_clk);
    if (bounce) bouncePrefix(mask);
    applyStimulus(mask, 10);
    repeat (10) @(negedge sys_clk);
    applyModel(mask);
  endtask

  // Returns on the first sample where mode differs from its value before the press
  task automatic pressDetect(input logic [3:0] mask, input bit bounce);
    logic [1:0] old;
    bit found = 1'b0;
    repeat (8) @(negedge sys_clk);
    if (bounce) bouncePrefix(mask);
    @(negedge sys_clk);
    old = mode;
    key = key & ~mask;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (i == 10) key = key | mask;
      if (mode !== old) begin
        found = 1'b1;
        break;
      end
    end
    key = key | mask;
    checks++;
    assert (found) else begin
      errors++;
      $error("[TB] FAIL mode_change_timeout: observed mode %0d, expected a change from %0d", mode, old);
    end
    applyModel(mask);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] frozen;
    bit         found;

    #1 sys_rst_n = 1'b0;
    #1;
    checkOutput("reset_led", led, 4'h0);
    checkOutput("reset_mode", {2'b00, mode}, 4'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Glitch one cycle shorter than the debounce window alone must not press
    bouncePrefix(4'b0001);
    repeat (15) @(negedge sys_clk);
    checkMode("glitch_no_press");

    pressDetect(4'b0001, 1'b1);
    checkMode("bounce_mode");
    checkOutput("bounce_led_lag", led, 4'h0);
    @(negedge sys_clk);
    checkOutput("bounce_led", led, 4'hF);
    repeat (20) @(negedge sys_clk);
    checkMode("bounce_single_press");

    pressDetect(4'b0001, 1'b0);
    checkMode("run_mode");
    checkOutput("run_led_lag", led, 4'hF);
    for (int i = 1; i <= 33; i++) begin
      @(negedge sys_clk);
      checkOutput("run_step", led, run_pattern(4'b0001, m_dir, i / STEP));
    end

    pressKey(4'b0100, 1'b0);
    frozen = led;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      checkOutput("pause_hold", led, frozen);
    end
    pressKey(4'b1000, 1'b0);
    checkOutput("pause_dir_hold", led, frozen);

    found = 1'b0;
    @(negedge sys_clk);
    key[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (i == 10) key[2] = 1'b1;
      if (led !== frozen) begin
        found = 1'b1;
        break;
      end
    end
    key[2] = 1'b1;
    applyModel(4'b0100);
    checks++;
    assert (found) else begin
      errors++;
      $error("[TB] FAIL resume_timeout: observed %b, expected a change from %b", led, frozen);
    end
    checkOutput("resume_dir", led, run_pattern(frozen, m_dir, 1));

    pressDetect(4'b0001, 1'b0);
    checkMode("blink_mode");
    for (int i = 1; i <= 17; i++) begin
      @(negedge sys_clk);
      checkOutput("blink_step", led, blink_pattern(i / STEP));
    end

    pressDetect(4'b0001, 1'b0);
    checkMode("wrap_up");
    @(negedge sys_clk);
    checkOutput("off_led", led, 4'h0);
    pressDetect(4'b0010, 1'b0);
    checkMode("wrap_down");
    pressDetect(4'b0010, 1'b0);
    checkMode("down_3_2");
    pressDetect(4'b0010, 1'b0);
    checkMode("down_2_1");
    pressDetect(4'b0011, 1'b0);
    checkMode("key0_priority");
    pressDetect(4'b0010, 1'b0);
    checkMode("down_2_1b");

    repeat (10) @(negedge sys_clk);
    applyModel(4'b0001);
    key[0] = 1'b0;
    repeat (12) @(negedge sys_clk);
    checkMode("long_first_press");
    repeat (38) @(negedge sys_clk);
`ifdef KEY_LONG_PRESS_EN
    m_mode = 0;
`endif
    checkMode("long_hold");
    repeat (30) @(negedge sys_clk);
    checkMode("long_once");
    key[0] = 1'b1;
    repeat (20) @(negedge sys_clk);
    checkMode("long_release");

    for (int t = 0; t < 4 && m_mode != 1; t++) pressDetect(4'b0001, 1'b0);
    repeat (3) @(negedge sys_clk);
    checkMode("pre_reset_mode");
    checkOutput("pre_reset_led", led, 4'hF);
    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_led", led, 4'h0);
    checkOutput("async_reset_mode", {2'b00, mode}, 4'h0);
    m_mode = 0;
    m_dir = 1'b0;
    m_paused = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    checkMode("post_reset_mode");
    checkOutput("post_reset_led", led, 4'h0);

    for (int n = 0; n < 24; n++) begin
      logic [3:0] mask;
      mask = 4'(1 << $urandom_range(0, 3));
      pressKey(mask, 1'($urandom_range(0, 1)));
      checkMode("rnd_mode");
      case (m_mode)
        0: checkOutput("rnd_off_led", led, 4'h0);
        1: checkOutput("rnd_on_led", led, 4'hF);
        2: checkOutput("rnd_run_onehot", 4'($countones(led)), 4'd1);
        default: checkOutput("rnd_blink_led", {3'b000, (led == 4'hF) || (led == 4'h0)}, 4'd1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
